// File: rtl/pll_rst_ctrl_pkg.sv
// ============================================================================
// Module   : pll_rst_ctrl_pkg
// Brief    : Shared state encoding, stats width and counter sizing helper
//            for the PLL reset controller.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package pll_rst_ctrl_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam int STAT_W = 8;

  // One counter is shared by all phases, so it is sized for the longest one.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pll_rst_ctrl_sync2.sv
// ============================================================================
// Module   : pll_rst_ctrl_sync2
// Brief    : Two-flop synchronizer for the PLL locked flag, resets to 0.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pll_rst_ctrl_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], i_d};
    end
  end

  assign o_q = r_sync[1];

endmodule

`default_nettype wire

// File: rtl/pll_rst_ctrl.sv
// ============================================================================
// Module   : pll_rst_ctrl
// Brief    : Pulses the PLL reset, waits for lock with a timeout, debounces
//            lock and only then releases the core reset. Optional retry and
//            lock-loss statistics are enabled by PLL_RST_CTRL_STATS_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pll_rst_ctrl
  import pll_rst_ctrl_pkg::*;
#(
  parameter int RST_CYCLES    = 32,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pll_locked,
  output logic              pll_rst,
  output logic              core_rst_n,
  output logic              ready
`ifdef PLL_RST_CTRL_STATS_EN
  ,
  output logic [STAT_W-1:0] retry_cnt,
  output logic              lock_lost
`endif
);

  localparam int CW = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

  localparam logic [CW-1:0] C_RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] C_TO_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] C_ST_LAST  = CW'(STABLE_CYCLES - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            r_pll_rst;
  logic            r_core_rst_n;
  logic            r_ready;
  logic            w_lk_s;

  pll_rst_ctrl_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (pll_locked),
    .o_q   (w_lk_s)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      PLL_RST: begin
        if (r_cnt == C_RST_LAST) begin
          w_state_nxt = WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      WAIT_LOCK: begin
        // Lock is checked first so it wins on the timeout cycle.
        if (w_lk_s) begin
          w_state_nxt = STABLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == C_TO_LAST) begin
          w_state_nxt = PLL_RST;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      STABLE: begin
        if (!w_lk_s) begin
          w_state_nxt = WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == C_ST_LAST) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      RUN: begin
        if (!w_lk_s) begin
          w_state_nxt = PLL_RST;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = PLL_RST;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they move with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= PLL_RST;
      r_cnt        <= '0;
      r_pll_rst    <= 1'b1;
      r_core_rst_n <= 1'b0;
      r_ready      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_pll_rst    <= (w_state_nxt == PLL_RST);
      r_core_rst_n <= (w_state_nxt == RUN);
      r_ready      <= (w_state_nxt == RUN);
    end
  end

  assign pll_rst    = r_pll_rst;
  assign core_rst_n = r_core_rst_n;
  assign ready      = r_ready;

`ifdef PLL_RST_CTRL_STATS_EN
  logic              w_timeout;
  logic              w_lost;
  logic [STAT_W-1:0] r_retry_cnt;
  logic              r_lock_lost;

  assign w_timeout = (r_state == WAIT_LOCK) && (w_state_nxt == PLL_RST);
  assign w_lost    = (r_state == RUN) && (w_state_nxt == PLL_RST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retry_cnt <= '0;
      r_lock_lost <= 1'b0;
    end else begin
      if (w_timeout && (r_retry_cnt != {STAT_W{1'b1}})) begin
        r_retry_cnt <= r_retry_cnt + 1'b1;
      end
      if (w_lost) begin
        r_lock_lost <= 1'b1;
      end
    end
  end

  assign retry_cnt = r_retry_cnt;
  assign lock_lost = r_lock_lost;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pll_rst_ctrl.sv
// ============================================================================
// Module   : tb_pll_rst_ctrl
// Brief    : Self-checking bench for pll_rst_ctrl with a timestamp-based
//            reference model of the reset sequencing.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pll_rst_ctrl;

  localparam int P_RST = 4;
  localparam int P_TO  = 16;
  localparam int P_ST  = 8;

  logic clk;
  logic rst_n;
  logic pll_locked;
  logic pll_rst;
  logic core_rst_n;
  logic ready;
`ifdef PLL_RST_CTRL_STATS_EN
  logic [7:0] retry_cnt;
  logic       lock_lost;
`endif

  int n_chk = 0;
  int n_err = 0;

  pll_rst_ctrl #(
    .RST_CYCLES    (P_RST),
    .LOCK_TIMEOUT  (P_TO),
    .STABLE_CYCLES (P_ST)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .pll_rst    (pll_rst),
    .core_rst_n (core_rst_n),
    .ready      (ready)
`ifdef PLL_RST_CTRL_STATS_EN
    ,
    .retry_cnt  (retry_cnt),
    .lock_lost  (lock_lost)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase 0=PLL reset, 1=wait lock, 2=stable, 3=run.
  // Each phase remembers the edge it started on; rules use elapsed edges.
  int k = 0;
  int m_phase;
  int m_tenter;
  int m_retry;
  bit m_lost;
  bit m_q[$];

  task automatic model_reset();
    m_phase  = 0;
    m_tenter = k;
    m_retry  = 0;
    m_lost   = 1'b0;
    m_q      = {1'b0, 1'b0};
  endtask

  task automatic enter(input int p);
    m_phase  = p;
    m_tenter = k;
  endtask

  task automatic model_edge();
    bit lk;
    int n;
    if (!rst_n) begin
      model_reset();
      return;
    end
    lk = m_q[0];
    m_q.push_back(pll_locked);
    void'(m_q.pop_front());
    n = k - m_tenter;
    case (m_phase)
      0: if (n == P_RST) enter(1);
      1: begin
        if (lk) enter(2);
        else if (n == P_TO) begin
          enter(0);
          if (m_retry < 255) m_retry++;
        end
      end
      2: begin
        if (!lk) enter(1);
        else if (n == P_ST) enter(3);
      end
      default: begin
        if (!lk) begin
          enter(0);
          m_lost = 1'b1;
        end
      end
    endcase
  endtask

  function automatic logic [2:0] m_out();
    return {m_phase == 0, m_phase == 3, m_phase == 3};
  endfunction

  task automatic tick();
    @(posedge clk);
    k++;
    model_edge();
    #1;
  endtask

  task automatic apply_reset(input int cycles);
    rst_n = 1'b0;
    model_reset();
    repeat (cycles) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    pll_locked = 1'b0;
    apply_reset(3);
    rst_n = 1'b0;
    n_chk++;
    if ({pll_rst, core_rst_n, ready} !== 3'b100) begin
      n_err++;
      $display("FAIL reset_outs got %b exp %b", {pll_rst, core_rst_n, ready}, 3'b100);
    end
`ifdef PLL_RST_CTRL_STATS_EN
    n_chk++;
    if (retry_cnt !== 8'd0 || lock_lost !== 1'b0) begin
      n_err++;
      $display("FAIL reset_stats got %0d/%b exp 0/0", retry_cnt, lock_lost);
    end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_power_up();
    int cnt;
    cnt = 0;
    pll_locked = 1'b0;
    do begin
      tick(); cnt++; n_chk++;
      if ({pll_rst, core_rst_n, ready} !== m_out()) begin
        n_err++;
        $display("FAIL power_up_outs got %b exp %b", {pll_rst, core_rst_n, ready}, m_out());
      end
    end while (pll_rst && cnt < 100);
    n_chk++;
    if (cnt != P_RST) begin
      n_err++;
      $display("FAIL power_up_rst_len got %0d exp %0d", cnt, P_RST);
    end
    repeat (3) begin
      tick(); n_chk++;
      if ({pll_rst, core_rst_n, ready} !== m_out()) begin
        n_err++;
        $display("FAIL power_up_wait got %b exp %b", {pll_rst, core_rst_n, ready}, m_out());
      end
    end
    pll_locked = 1'b1;
    cnt = 0;
    do begin
      tick(); cnt++; n_chk++;
      if ({pll_rst, core_rst_n, ready} !== m_out()) begin
        n_err++;
        $display("FAIL power_up_lock got %b exp %b", {pll_rst, core_rst_n, ready}, m_out());
      end
    end while (!core_rst_n && cnt < 200);
    // Two sync flops, one WAIT_LOCK decision, then STABLE_CYCLES.
    n_chk++;
    if (cnt != 2 + 1 + P_ST) begin
      n_err++;
      $display("FAIL power_up_release got %0d exp %0d", cnt, 2 + 1 + P_ST);
    end
  endtask

  task automatic test_no_lock();
    int rises[$];
    logic prev;
    pll_locked = 1'b0;
    apply_reset(2);
    prev = 1'b1;
    for (int t = 1; t <= 3 * (P_RST + P_TO) + 2; t++) begin
      tick(); n_chk++;
      if ({pll_rst, core_rst_n, ready} !== m_out()) begin
        n_err++;
        $display("FAIL no_lock_outs got %b exp %b t=%0d", {pll_rst, core_rst_n, ready}, m_out(), t);
      end
      if (pll_rst && !prev) begin
        rises.push_back(t);
`ifdef PLL_RST_CTRL_STATS_EN
        n_chk++;
        if (retry_cnt !== 8'(rises.size())) begin
          n_err++;
          $display("FAIL no_lock_retry got %0d exp %0d", retry_cnt, rises.size());
        end
`endif
      end
      prev = pll_rst;
    end
    n_chk++;
    if (rises.size() != 3) begin
      n_err++;
      $display("FAIL no_lock_pulses got %0d exp 3", rises.size());
    end else begin
      foreach (rises[i]) begin
        n_chk++;
        if (rises[i] != (i + 1) * (P_RST + P_TO)) begin
          n_err++;
          $display("FAIL no_lock_period got %0d exp %0d", rises[i], (i + 1) * (P_RST + P_TO));
        end
      end
    end
  endtask

  task automatic test_glitch();
    int cnt;
    bit saw_rst;
    pll_locked = 1'b0;
    apply_reset(2);
    cnt = 0;
    do begin
      tick(); cnt++;
    end while (pll_rst && cnt < 100);
    pll_locked = 1'b1;
    repeat (5) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    cnt = 0;
    saw_rst = 1'b0;
    do begin
      tick(); cnt++; n_chk++;
      if (pll_rst) saw_rst = 1'b1;
      if ({pll_rst, core_rst_n, ready} !== m_out()) begin
        n_err++;
        $display("FAIL glitch_outs got %b exp %b", {pll_rst, core_rst_n, ready}, m_out());
      end
    end while (!core_rst_n && cnt < 200);
    n_chk++;
    if (cnt != 2 + 1 + P_ST || saw_rst) begin
      n_err++;
      $display("FAIL glitch_release got %0d/%b exp %0d/0", cnt, saw_rst, 2 + 1 + P_ST);
    end
  endtask

  task automatic test_loss_in_run();
    int cnt;
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    cnt = 1;
    while (core_rst_n && cnt < 50) begin
      tick(); cnt++;
    end
    n_chk++;
    if (cnt != 3 || ready !== 1'b0 || pll_rst !== 1'b1) begin
      n_err++;
      $display("FAIL loss_drop got %0d/%b/%b exp 3/0/1", cnt, ready, pll_rst);
    end
    cnt = 0;
    do begin
      tick(); cnt++; n_chk++;
      if ({pll_rst, core_rst_n, ready} !== m_out()) begin
        n_err++;
        $display("FAIL loss_outs got %b exp %b", {pll_rst, core_rst_n, ready}, m_out());
      end
    end while (pll_rst && cnt < 100);
    n_chk++;
    if (cnt != P_RST) begin
      n_err++;
      $display("FAIL loss_rst_len got %0d exp %0d", cnt, P_RST);
    end
`ifdef PLL_RST_CTRL_STATS_EN
    n_chk++;
    if (lock_lost !== 1'b1) begin
      n_err++;
      $display("FAIL loss_sticky got %b exp 1", lock_lost);
    end
`endif
  endtask

  task automatic test_async_reset();
    int cnt;
    pll_locked = 1'b0;
    apply_reset(2);
    cnt = 0;
    do begin
      tick(); cnt++;
    end while (pll_rst && cnt < 100);
    pll_locked = 1'b1;
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_chk++;
    if ({pll_rst, core_rst_n, ready} !== 3'b100) begin
      n_err++;
      $display("FAIL async_rst_outs got %b exp 100", {pll_rst, core_rst_n, ready});
    end
    repeat (2) tick();
    rst_n = 1'b1;
    cnt = 0;
    do begin
      tick(); cnt++; n_chk++;
      if ({pll_rst, core_rst_n, ready} !== m_out()) begin
        n_err++;
        $display("FAIL async_rst_seq got %b exp %b", {pll_rst, core_rst_n, ready}, m_out());
      end
    end while (!core_rst_n && cnt < 200);
    // Lock is already visible when WAIT_LOCK is entered.
    n_chk++;
    if (cnt != P_RST + 1 + P_ST) begin
      n_err++;
      $display("FAIL async_rst_release got %0d exp %0d", cnt, P_RST + 1 + P_ST);
    end
  endtask

  task automatic test_timeout_race();
    int cnt;
    pll_locked = 1'b0;
    apply_reset(2);
    // lk_s must first read 1 on the edge where the timeout would fire.
    repeat (P_RST + P_TO - 3) tick();
    pll_locked = 1'b1;
    repeat (3) tick();
    n_chk++;
    if (pll_rst !== 1'b0 || m_phase != 2) begin
      n_err++;
      $display("FAIL race_no_retry got pll_rst=%b exp 0", pll_rst);
    end
`ifdef PLL_RST_CTRL_STATS_EN
    n_chk++;
    if (retry_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL race_retry_cnt got %0d exp 0", retry_cnt);
    end
`endif
    cnt = 0;
    do begin
      tick(); cnt++; n_chk++;
      if ({pll_rst, core_rst_n, ready} !== m_out()) begin
        n_err++;
        $display("FAIL race_outs got %b exp %b", {pll_rst, core_rst_n, ready}, m_out());
      end
    end while (!core_rst_n && cnt < 100);
    n_chk++;
    if (cnt != P_ST) begin
      n_err++;
      $display("FAIL race_release got %0d exp %0d", cnt, P_ST);
    end
  endtask

  task automatic test_random();
    int seg;
    seg = 0;
    for (int i = 0; i < 1200; i++) begin
      if (!rst_n) rst_n = 1'b1;
      if (seg == 0) begin
        pll_locked = 1'($urandom_range(0, 1));
        seg = int'($urandom_range(1, 40));
      end
      seg--;
      if ($urandom_range(0, 249) == 0) begin
        #2;
        rst_n = 1'b0;
        model_reset();
      end
      tick(); n_chk++;
      if ({pll_rst, core_rst_n, ready} !== m_out()) begin
        n_err++;
        $display("FAIL random_outs got %b exp %b i=%0d", {pll_rst, core_rst_n, ready}, m_out(), i);
      end
`ifdef PLL_RST_CTRL_STATS_EN
      n_chk++;
      if (retry_cnt !== 8'(m_retry) || lock_lost !== m_lost) begin
        n_err++;
        $display("FAIL random_stats got %0d/%b exp %0d/%b", retry_cnt, lock_lost, m_retry, m_lost);
      end
`endif
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    model_reset();
    test_reset();
    test_power_up();
    test_no_lock();
    test_glitch();
    test_loss_in_run();
    test_async_reset();
    test_timeout_race();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
